// File: rtl/md_unit_sched_if.sv
// E-stage <-> multiply/divide unit bundle. The cancel wire exists only when MD_CANCEL_EN is defined.
interface md_unit_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start_err;

`ifdef MD_CANCEL_EN
  modport master (output start, op, a, b, d_md, cancel,
                  input  busy, stall, hi, lo, start_err);
  modport slave  (input  start, op, a, b, d_md, cancel,
                  output busy, stall, hi, lo, start_err);
`else
  modport master (output start, op, a, b, d_md,
                  input  busy, stall, hi, lo, start_err);
  modport slave  (input  start, op, a, b, d_md,
                  output busy, stall, hi, lo, start_err);
`endif
endinterface

// File: rtl/md_unit_sched.sv
// Multi-cycle MIPS mult/div scheduler holding HI/LO and raising the D-stage stall.
// Optional MD_CANCEL_EN adds a cancel input that aborts an in-flight op or kills a same-cycle start.
module md_unit_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_unit_sched_if.slave md
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state;
  logic [7:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        kill;
  logic        op_valid;
  logic        op_long;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

`ifdef MD_CANCEL_EN
  assign kill = md.cancel;
`else
  assign kill = 1'b0;
`endif

  assign op_valid = md.start && (md.op <= 3'd5);
  assign op_long  = md.start && (md.op <= 3'd3);
  assign is_div   = md.op[1];

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign neg_a   = (md.op == 3'd2) && md.a[31];
  assign neg_b   = (md.op == 3'd2) && md.b[31];
  assign abs_a   = neg_a ? (32'd0 - md.a) : md.a;
  assign abs_b   = neg_b ? (32'd0 - md.b) : md.b;
  assign divisor = (md.b == 32'd0) ? 32'd1 : abs_b;
  assign uq      = abs_a / divisor;
  assign ur      = abs_a % divisor;
  assign quo     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem     = neg_a ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi = rem;
    res_lo = quo;
    unique case (md.op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      default: ;
    endcase
  end

  assign md.stall = md.d_md && (md.busy || op_long);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      count        <= 8'd0;
      pend_hi      <= 32'd0;
      pend_lo      <= 32'd0;
      pend_wr      <= 1'b0;
      md.busy      <= 1'b0;
      md.hi        <= 32'd0;
      md.lo        <= 32'd0;
      md.start_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (op_valid && !kill) begin
            if (md.op[2]) begin
              if (md.op[0]) md.lo <= md.a;
              else          md.hi <= md.a;
            end else begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              // Divide by zero still burns the full latency but leaves HI/LO alone.
              pend_wr <= !(is_div && (md.b == 32'd0));
              count   <= is_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
              state   <= StRun;
              md.busy <= 1'b1;
            end
          end
        end
        StRun: begin
          if (op_valid) md.start_err <= 1'b1;
          if (kill) begin
            state   <= StIdle;
            count   <= 8'd0;
            pend_wr <= 1'b0;
            md.busy <= 1'b0;
          end else if (count == 8'd1) begin
            if (pend_wr) begin
              md.hi <= pend_hi;
              md.lo <= pend_lo;
            end
            state   <= StIdle;
            count   <= 8'd0;
            md.busy <= 1'b0;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_sched.sv
// Scoreboard bench for md_unit_sched: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks them when busy falls.
module tb_md_unit_sched;

  logic clk;
  logic reset;

  md_unit_sched_if bus ();

  md_unit_sched #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: hold check on every busy cycle, result and latency check when busy falls.
  initial begin
    int   cnt;
    logic prev;
    exp_t e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        cnt++;
        if (exp_q.size() > 0)
          check("hold_hilo", {bus.hi, bus.lo}, {exp_q[0].pre_hi, exp_q[0].pre_lo});
      end else if (prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {32'd0, cnt}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_hilo", {bus.hi, bus.lo}, {e.hi, e.lo});
          check("busy_cycles", {32'd0, cnt}, {32'd0, e.len});
        end
        cnt = 0;
      end
      prev = (bus.busy === 1'b1);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1'b1;
    end
    if (!done) check("busy_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input int len);
    exp_t e;
    e.hi = eh; e.lo = el; e.pre_hi = model_hi; e.pre_lo = model_lo; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int len);
    push(eh, el, len);
    issue(o, x, y);
    wait_idle();
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.d_md  = 1'b0;
`ifdef MD_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    #22;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_err", {63'd0, bus.start_err}, 64'd0);
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h1234_5678});
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    model_hi = 32'h1234_5678;
    run_op(3'd2, 32'd55, 32'd0, 32'h1234_5678, 32'hFFFF_FFFD, 10);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

    issue(3'd5, 32'hCAFE_0001, 32'd0);
    check("mtlo_lo", {32'd0, bus.lo}, {32'd0, 32'hCAFE_0001});
    model_lo = 32'hCAFE_0001;

    // Reserved op: no state change, no error.
    issue(3'd6, 32'hDEAD_BEEF, 32'd3);
    check("rsvd_busy", {63'd0, bus.busy}, 64'd0);
    check("rsvd_err", {63'd0, bus.start_err}, 64'd0);
    check("rsvd_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

    // Stall boundaries with d_md held.
    bus.d_md = 1'b1;
    #1 check("stall_idle", {63'd0, bus.stall}, 64'd0);
    bus.start = 1'b1; bus.op = 3'd4;
    #1 check("stall_mthi", {63'd0, bus.stall}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);

    // multu with d_md, plus an illegal start while busy.
    push(32'd1, 32'hFFFF_FFFE, 5);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
    #1 check("stall_start", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    #1 bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    check("stall_busy1", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_busy", {63'd0, bus.stall}, 64'd1);
    end
    @(negedge clk);
    check("stall_fall", {63'd0, bus.stall}, 64'd0);
    check("busy_fall", {63'd0, bus.busy}, 64'd0);
    check("start_err", {63'd0, bus.start_err}, 64'd1);
    model_hi = 32'd1;
    model_lo = 32'hFFFF_FFFE;
    bus.d_md = 1'b0;

    // Reset during busy cycle 3 of a div.
    push(32'd0, 32'd0, 2);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_err", {63'd0, bus.start_err}, 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);

`ifdef MD_CANCEL_EN
    issue(3'd4, 32'd1, 32'd0);
    issue(3'd5, 32'd2, 32'd0);
    model_hi = 32'd1;
    model_lo = 32'd2;
    // Cancel in idle kills a same-cycle mthi.
    bus.cancel = 1'b1;
    issue(3'd4, 32'h7777_7777, 32'd0);
    bus.cancel = 1'b0;
    check("cancel_mthi", {bus.hi, bus.lo}, {32'd1, 32'd2});
    push(32'd1, 32'd2, 2);
    issue(3'd0, 32'd9, 32'd9);
    @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
